fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline. It holds the PC, drives the instruction-ROM address, and registers the fetched word into the IF/ID pipeline register. It consumes the 2-bit `npc_op` redirect that the control decoder produced and the EX stage resolved, and stops fetching when an all-zero instruction reaches ID (the decoder's `PC_en` = 0 condition).

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `CNT_W`, 16, width of the saturating redirect counter.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  load-use stall from hazard unit; holds PC and IF/ID.
- `ex_valid`  in  1  EX stage holds a real (non-bubble) instruction.
- `ex_npc_op`  in  2  resolved next-PC op of the EX instruction: 00 seq, 01 taken branch, 10 jal, 11 jalr.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_imm`  in  32  sign-extended immediate of the EX instruction.
- `ex_alu_c`  in  32  ALU result of the EX instruction (rs1+imm for jalr).
- `irom_addr`  out  32  byte address to instruction ROM (= PC).
- `irom_inst`  in  32  instruction word, combinational read of `irom_addr`.
- `id_inst`  out  32  IF/ID instruction.
- `id_pc`  out  32  IF/ID PC.
- `id_pc4`  out  32  IF/ID PC+4 (jal/jalr write-back value).
- `id_valid`  out  1  IF/ID holds a real instruction.
- `flush_idex`  out  1  combinational; bubble the ID/EX register this cycle.
- `halted`  out  1  sticky; fetch stopped.
- `redirect_cnt`  out  CNT_W  count of taken redirects, saturating.

## Operation
- `redirect` = `ex_valid` && `ex_npc_op` != 00. Target: op 01/10 → `ex_pc`+`ex_imm`; op 11 → `ex_alu_c` with bit 0 cleared. Adds are mod 2^32.
- Per-edge priority: reset > redirect > halted > stall > sequential.
- Redirect: PC ← target; IF/ID ← bubble (`id_valid`=0, `id_inst`=32'h0000_0013); `flush_idex`=1; `redirect_cnt` += 1, saturating at all-ones. A redirect overrides both `stall` and a pending halt.
- Halt detect: `id_valid` && `id_inst`==0 && !redirect → at the edge, `halted`←1 and IF/ID ← bubble. `halted` stays set until reset. While halted, PC is frozen and IF/ID keeps the bubble.
- Stall (no redirect, not halted): PC, `id_inst`, `id_pc`, `id_pc4`, `id_valid` all hold.
- Sequential: PC ← PC+4; IF/ID ← {`irom_inst`, PC, PC+4, valid=1}.
- PC wraps: 32'hFFFF_FFFC + 4 → 32'h0000_0000, no flag.
- Reset values: PC=`RESET_PC`, `id_inst`=32'h0000_0013, `id_pc`=0, `id_pc4`=0, `id_valid`=0, `halted`=0, `redirect_cnt`=0. `flush_idex` follows its inputs.

## Timing
- `irom_addr` equals the PC register, with zero-cycle ROM latency. An instruction enters ID one edge after its PC is presented.
- Redirect penalty is 2 bubbles: the IF/ID entry (IF/ID flush) and the instruction in ID (`flush_idex`). The target instruction is in ID 2 edges after the redirect cycle.
- Reset may assert mid-stall or mid-redirect. It clears asynchronously, and the first fetch is at `RESET_PC` on the first edge after deassertion.
- `stall` is sampled every edge and has no latency.

## Structure
- Shared `cpu_pkg`: `XLEN`=32, the `NPC_SEQ`/`NPC_BR`/`NPC_JAL`/`NPC_JALR` encodings (00/01/10/11, common with the control decoder), and `INST_NOP`=32'h0000_0013.
- One combinational sub-module, `npc_gen`. It takes PC, `ex_*`, `stall` and `halted`, and produces the next PC and `redirect`. `fetch_stage` owns all registers.

## Test plan
- Reset with `RESET_PC`=32'h100, no stall, ROM returns addi words → `irom_addr` is 0x100, 0x104, 0x108; `id_valid` rises one edge after reset release with `id_pc`=0x100 and `id_pc4`=0x104.
- `stall` high 3 cycles at PC=0x10 → PC and IF/ID frozen for 3 edges, then resume at 0x14.
- `ex_valid`=1, op=01, `ex_pc`=0x20, `ex_imm`=-8 while `stall`=1 → `flush_idex`=1 that cycle, next PC 0x18, `id_valid`=0 next edge, `redirect_cnt` goes 0→1.
- op=11 with `ex_alu_c`=0x203 → next PC 0x202. Op=10 with `ex_pc`=0xFFFF_FFF0 and `ex_imm`=0x20 → next PC 0x10 (wrap).
- ROM word 0 reaches ID → `halted`=1 next edge, PC frozen. Same scenario with a simultaneous redirect → `halted` stays 0 and PC goes to the target.
- 65,540 consecutive redirects with `CNT_W`=16 → `redirect_cnt` saturates at 0xFFFF. Async `rst` pulse mid-run → all outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared RV32I pipeline types, next-PC encodings and constants
package cpu_pkg;

    localparam int XLEN = 32;

    // Encoding is shared with the control decoder; do not renumber.
    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_BR   = 2'b01,
        NPC_JAL  = 2'b10,
        NPC_JALR = 2'b11
    } npc_op_e;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        inst:  INST_NOP,
        pc:    '0,
        pc4:   '0,
        valid: 1'b0
    };

    function automatic logic [XLEN-1:0] jalr_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage signal bundle: EX redirect, ROM port, IF/ID outputs
interface fetch_stage_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic             stall;
    logic             ex_valid;
    logic [1:0]       ex_npc_op;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_imm;
    logic [XLEN-1:0]  ex_alu_c;
    logic [XLEN-1:0]  irom_addr;
    logic [XLEN-1:0]  irom_inst;
    logic [XLEN-1:0]  id_inst;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_pc4;
    logic             id_valid;
    logic             flush_idex;
    logic             halted;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        input  stall, ex_valid, ex_npc_op, ex_pc, ex_imm, ex_alu_c, irom_inst,
        output irom_addr, id_inst, id_pc, id_pc4, id_valid, flush_idex, halted, redirect_cnt
    );

    modport slave (
        output stall, ex_valid, ex_npc_op, ex_pc, ex_imm, ex_alu_c, irom_inst,
        input  irom_addr, id_inst, id_pc, id_pc4, id_valid, flush_idex, halted, redirect_cnt
    );

endinterface

// File: rtl/fetch_stage_npc_gen.sv
// rtl/fetch_stage_npc_gen.sv - combinational next-PC select and redirect detect
module npc_gen
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            ex_valid,
    input  logic [1:0]      ex_npc_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_alu_c,
    input  logic            stall,
    input  logic            halted,
    output logic [XLEN-1:0] npc,
    output logic [XLEN-1:0] pc4,
    output logic            redirect
);

    npc_op_e         op;
    logic [XLEN-1:0] target;

    assign op       = npc_op_e'(ex_npc_op);
    assign pc4      = pc + 32'd4;
    assign redirect = ex_valid && (op != NPC_SEQ);

    always_comb begin
        target = ex_pc + ex_imm;
        if (op == NPC_JALR) begin
            target = jalr_align(ex_alu_c);
        end
    end

    // Redirect outranks both halt and stall so a resolved jump is never lost.
    always_comb begin
        npc = pc4;
        if (redirect) begin
            npc = target;
        end else if (halted || stall) begin
            npc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, ROM address and IF/ID pipeline register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 16
)(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0]  pc_q, pc_d;
    ifid_t            ifid_q, ifid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  pc4;
    logic             redirect;
    logic             halt_hit;

    // An all-zero word in ID is the decoder's stop condition.
    assign halt_hit = ifid_q.valid && (ifid_q.inst == '0);

    npc_gen u_npc_gen (
        .pc        (pc_q),
        .ex_valid  (bus.ex_valid),
        .ex_npc_op (bus.ex_npc_op),
        .ex_pc     (bus.ex_pc),
        .ex_imm    (bus.ex_imm),
        .ex_alu_c  (bus.ex_alu_c),
        .stall     (bus.stall),
        .halted    (halted_q || halt_hit),
        .npc       (npc),
        .pc4       (pc4),
        .redirect  (redirect)
    );

    always_comb begin
        pc_d           = npc;
        ifid_d         = ifid_q;
        halted_d       = halted_q;
        redirect_cnt_d = redirect_cnt_q;
        if (redirect) begin
            ifid_d = IFID_BUBBLE;
            if (!(&redirect_cnt_q)) begin
                redirect_cnt_d = redirect_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (halted_q || halt_hit) begin
            halted_d = 1'b1;
            ifid_d   = IFID_BUBBLE;
        end else if (!bus.stall) begin
            ifid_d = '{inst: bus.irom_inst, pc: pc_q, pc4: pc4, valid: 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            ifid_q         <= IFID_BUBBLE;
            halted_q       <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            pc_q           <= pc_d;
            ifid_q         <= ifid_d;
            halted_q       <= halted_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.irom_addr    = pc_q;
    assign bus.id_inst      = ifid_q.inst;
    assign bus.id_pc        = ifid_q.pc;
    assign bus.id_pc4       = ifid_q.pc4;
    assign bus.id_valid     = ifid_q.valid;
    assign bus.flush_idex   = redirect;
    assign bus.halted       = halted_q;
    assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic clk;
    logic rst;
    logic        zero_en;
    logic [31:0] zero_addr;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_cmp;
    int          n_err;

    fetch_stage_if #(.CNT_W(16)) bus ();

    fetch_stage #(.RESET_PC(32'h100), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    always_comb begin
        if (zero_en && bus.irom_addr == zero_addr) bus.irom_inst = 32'h0;
        else bus.irom_inst = rom_word(bus.irom_addr);
    end

    task automatic set_ex(input logic v, input logic [1:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] alu);
        bus.ex_valid  = v;
        bus.ex_npc_op = op;
        bus.ex_pc     = pc;
        bus.ex_imm    = imm;
        bus.ex_alu_c  = alu;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h100); exp_q.push_back(32'h13); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);   exp_q.push_back(32'h0);  exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_inst !== e) begin n_err++; $display("FAIL reset_inst: got %h want %h", bus.id_inst, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL reset_id_pc: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL reset_valid: got %h want %h", bus.id_valid, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.halted) !== e) begin n_err++; $display("FAIL reset_halted: got %h want %h", bus.halted, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL reset_cnt: got %h want %h", bus.redirect_cnt, e); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] pc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pc); exp_q.push_back(rom_word(pc)); exp_q.push_back(pc);
            exp_q.push_back(pc + 32'd4); exp_q.push_back(32'h1);
            e = exp_q.pop_front(); n_cmp++;
            if (bus.irom_addr !== e) begin n_err++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.irom_addr, e); end
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (bus.id_inst !== e) begin n_err++; $display("FAIL seq_inst%0d: got %h want %h", i, bus.id_inst, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (bus.id_pc !== e) begin n_err++; $display("FAIL seq_id_pc%0d: got %h want %h", i, bus.id_pc, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (bus.id_pc4 !== e) begin n_err++; $display("FAIL seq_id_pc4%0d: got %h want %h", i, bus.id_pc4, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL seq_valid%0d: got %h want %h", i, bus.id_valid, e); end
            pc = pc + 32'd4;
        end
    endtask

    task automatic test_stall();
        apply_reset();
        set_ex(1'b1, 2'b11, 32'h0, 32'h0, 32'hC);
        @(posedge clk); #1;
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h10); exp_q.push_back(32'hC); exp_q.push_back(rom_word(32'hC));
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (bus.irom_addr !== e) begin n_err++; $display("FAIL stall_pc%0d: got %h want %h", i, bus.irom_addr, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (bus.id_pc !== e) begin n_err++; $display("FAIL stall_id_pc%0d: got %h want %h", i, bus.id_pc, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (bus.id_inst !== e) begin n_err++; $display("FAIL stall_inst%0d: got %h want %h", i, bus.id_inst, e); end
        end
        @(negedge clk);
        bus.stall = 1'b0;
        exp_q.push_back(32'h14); exp_q.push_back(32'h10);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL stall_resume_pc: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL stall_resume_id_pc: got %h want %h", bus.id_pc, e); end
    endtask

    task automatic test_branch_redirect();
        apply_reset();
        @(posedge clk); #1;
        @(negedge clk);
        bus.stall = 1'b1;
        set_ex(1'b1, 2'b01, 32'h20, 32'hFFFF_FFF8, 32'h0);
        #1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.flush_idex) !== e) begin n_err++; $display("FAIL br_flush: got %h want %h", bus.flush_idex, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL br_cnt_before: got %h want %h", bus.redirect_cnt, e); end
        exp_q.push_back(32'h18); exp_q.push_back(32'h0); exp_q.push_back(32'h13); exp_q.push_back(32'h1);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL br_target: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL br_bubble_valid: got %h want %h", bus.id_valid, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_inst !== e) begin n_err++; $display("FAIL br_bubble_inst: got %h want %h", bus.id_inst, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL br_cnt_after: got %h want %h", bus.redirect_cnt, e); end
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        bus.stall = 1'b0;
        exp_q.push_back(32'h18); exp_q.push_back(32'h1);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL br_target_in_id: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL br_target_valid: got %h want %h", bus.id_valid, e); end
    endtask

    task automatic test_jump_targets();
        set_ex(1'b1, 2'b11, 32'h0, 32'h0, 32'h203);
        exp_q.push_back(32'h202);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL jalr_target: got %h want %h", bus.irom_addr, e); end
        set_ex(1'b1, 2'b10, 32'hFFFF_FFF0, 32'h20, 32'h0);
        exp_q.push_back(32'h10);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL jal_wrap: got %h want %h", bus.irom_addr, e); end
        set_ex(1'b1, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFD);
        exp_q.push_back(32'hFFFF_FFFC);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL jalr_top: got %h want %h", bus.irom_addr, e); end
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL pc_wrap: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL pc_wrap_id_pc: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc4 !== e) begin n_err++; $display("FAIL pc_wrap_id_pc4: got %h want %h", bus.id_pc4, e); end
    endtask

    task automatic test_halt();
        apply_reset();
        zero_en   = 1'b1;
        zero_addr = 32'h104;
        @(posedge clk); #1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_inst !== e) begin n_err++; $display("FAIL halt_zero_in_id: got %h want %h", bus.id_inst, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.halted) !== e) begin n_err++; $display("FAIL halt_not_yet: got %h want %h", bus.halted, e); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h1); exp_q.push_back(32'h108); exp_q.push_back(32'h0);
            @(posedge clk); #1;
            e = exp_q.pop_front(); n_cmp++;
            if (32'(bus.halted) !== e) begin n_err++; $display("FAIL halt_flag%0d: got %h want %h", i, bus.halted, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (bus.irom_addr !== e) begin n_err++; $display("FAIL halt_pc%0d: got %h want %h", i, bus.irom_addr, e); end
            e = exp_q.pop_front(); n_cmp++;
            if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL halt_valid%0d: got %h want %h", i, bus.id_valid, e); end
        end
    endtask

    task automatic test_halt_redirect();
        apply_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_ex(1'b1, 2'b10, 32'h40, 32'h0, 32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h40); exp_q.push_back(32'h0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.halted) !== e) begin n_err++; $display("FAIL hr_halted: got %h want %h", bus.halted, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL hr_target: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL hr_bubble: got %h want %h", bus.id_valid, e); end
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'h40); exp_q.push_back(32'h0);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL hr_id_pc: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.halted) !== e) begin n_err++; $display("FAIL hr_still_running: got %h want %h", bus.halted, e); end
        zero_en = 1'b0;
    endtask

    task automatic test_saturate();
        apply_reset();
        set_ex(1'b1, 2'b01, 32'h0, 32'h0, 32'h0);
        exp_q.push_back(32'hFFFE); exp_q.push_back(32'hFFFF); exp_q.push_back(32'hFFFF);
        repeat (65534) @(posedge clk);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL sat_cnt_m1: got %h want %h", bus.redirect_cnt, e); end
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL sat_cnt_max: got %h want %h", bus.redirect_cnt, e); end
        repeat (5) @(posedge clk);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL sat_cnt_hold: got %h want %h", bus.redirect_cnt, e); end
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_ex(1'b1, 2'b10, 32'h200, 32'h0, 32'h0);
        @(posedge clk); #1;
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        bus.stall = 1'b1;
        set_ex(1'b1, 2'b01, 32'h300, 32'h4, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h13); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);   exp_q.push_back(32'h0);  exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL ar_pc: got %h want %h", bus.irom_addr, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_inst !== e) begin n_err++; $display("FAIL ar_inst: got %h want %h", bus.id_inst, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL ar_id_pc: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc4 !== e) begin n_err++; $display("FAIL ar_id_pc4: got %h want %h", bus.id_pc4, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.id_valid) !== e) begin n_err++; $display("FAIL ar_valid: got %h want %h", bus.id_valid, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.redirect_cnt) !== e) begin n_err++; $display("FAIL ar_cnt: got %h want %h", bus.redirect_cnt, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (32'(bus.flush_idex) !== e) begin n_err++; $display("FAIL ar_flush_follows: got %h want %h", bus.flush_idex, e); end
        bus.stall = 1'b0;
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        @(posedge clk); #1;
        e = exp_q.pop_front(); n_cmp++;
        if (bus.id_pc !== e) begin n_err++; $display("FAIL ar_first_fetch: got %h want %h", bus.id_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (bus.irom_addr !== e) begin n_err++; $display("FAIL ar_next_pc: got %h want %h", bus.irom_addr, e); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        zero_en   = 1'b0;
        zero_addr = 32'h0;
        bus.stall = 1'b0;
        set_ex(1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_sequential();
        test_stall();
        test_branch_redirect();
        test_jump_targets();
        test_halt();
        test_halt_redirect();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
